rx_host_ptr_update: RTL and testbench

//  Consumer of the rx_turn grant on the RX side of the endpoint arbitration.

---
 rtl/rx_host_ptr_update_pkg.sv | 50 +++++
 rtl/tlp_mwr1_hdr_gen.sv | 29 ++
 rtl/rx_host_ptr_update.sv | 180 ++++++++++++++++++
 tb/tb_rx_host_ptr_update.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_host_ptr_update_pkg.sv
// Shared definitions for the RX host-pointer reporter: TLP format codes,
// FSM state encoding, TRN transmit idle values and a byte-swap helper.
package rx_host_ptr_update_pkg;

   // Memory Write header formats (with data).
   localparam logic [1:0] FMT_3DW_D = 2'b10;
   localparam logic [1:0] FMT_4DW_D = 2'b11;
   localparam logic [4:0] TYPE_MEM  = 5'b00000;

   // The report is always exactly one data DW.
   localparam logic [9:0] MWR1_LEN  = 10'd1;

   // TRN remainder encodings.
   localparam logic [7:0] TRN_REM_BOTH  = 8'h00;
   localparam logic [7:0] TRN_REM_UPPER = 8'h0F;

   // Packet sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_BEAT2 = 2'd3
   } state_t;

   // Everything this block presents on the TX side, registered together.
   typedef struct packed {
      logic        driven;
      logic        sof_n;
      logic        eof_n;
      logic        src_rdy_n;
      logic [7:0]  trem_n;
      logic [63:0] td;
   } trn_tx_t;

   // Bus released: no framing strobes, zero data.
   localparam trn_tx_t TRN_TX_IDLE = '{
      driven:    1'b0,
      sof_n:     1'b1,
      eof_n:     1'b1,
      src_rdy_n: 1'b1,
      trem_n:    TRN_REM_BOTH,
      td:        64'h0
   };

   // The host reads the pointer little-endian, so the payload DW is byte-reversed.
   function automatic logic [31:0] byte_swap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/tlp_mwr1_hdr_gen.sv
// Combinational header builder for a single-DW Memory Write TLP.
// Chooses 3DW or 4DW addressing from the upper address word.
module tlp_mwr1_hdr_gen
   import rx_host_ptr_update_pkg::*;
#(
   parameter logic [7:0] TLP_TAG = 8'h00,
   parameter logic [2:0] TLP_TC  = 3'b000
)(
   input  logic [31:0] i_addr_hi,
   input  logic [15:0] i_completer_id,
   output logic        o_use4dw,
   output logic [31:0] o_dw0,
   output logic [31:0] o_dw1
);

   logic [1:0] w_fmt;

   // Only addresses above 4 GB need the 64-bit header form.
   assign o_use4dw = (i_addr_hi != 32'h0);
   assign w_fmt    = o_use4dw ? FMT_4DW_D : FMT_3DW_D;

   // DW0: fmt/type, TC, no digest, not poisoned, default attributes, length 1.
   assign o_dw0 = {1'b0, w_fmt, TYPE_MEM, 1'b0, TLP_TC, 4'b0,
                   1'b0, 1'b0, 2'b00, 2'b00, MWR1_LEN};

   // DW1: requester ID, tag, last BE = 0 (single DW), first BE = all bytes.
   assign o_dw1 = {i_completer_id, TLP_TAG, 4'h0, 4'hF};

endmodule

// File: rtl/rx_host_ptr_update.sv
// RX host-pointer reporter. On an arbiter grant, if the committed RX pointer
// differs from the last value reported, posts it to host memory as a 1-DW
// Memory Write on the 64-bit TRN TX interface, holding rx_driven while it
// owns the bus.
module rx_host_ptr_update
   import rx_host_ptr_update_pkg::*;
#(
   parameter logic [7:0] TLP_TAG = 8'h00,
   parameter logic [2:0] TLP_TC  = 3'b000
)(
   input  logic        trn_clk,
   input  logic        reset_n,
   input  logic        rx_turn,
   output logic        rx_driven,
   input  logic        enable,
   input  logic [63:0] host_ptr_addr,
   input  logic [31:0] committed_ptr,
   input  logic [15:0] cfg_completer_id,
   output logic [63:0] trn_td,
   output logic [7:0]  trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   input  logic        trn_tdst_rdy_n,
   input  logic        trn_tbuf_av
);

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_last_sent;
   logic [31:0] w_last_sent_next;
   logic [31:0] r_snap_ptr;
   logic [31:0] w_snap_ptr_next;
   logic [61:0] r_snap_addr;        // host address bits [63:2]
   logic [61:0] w_snap_addr_next;
   trn_tx_t     r_tx;
   trn_tx_t     w_tx_next;

   logic        w_pending;
   logic        w_accept;
   logic        w_start;
   logic        w_use4dw;
   logic [31:0] w_dw0;
   logic [31:0] w_dw1;
   logic [31:0] w_payload;
   logic        w_unused_addr_lsbs;

   // The slot is DW aligned; the two low address bits are never sent.
   assign w_unused_addr_lsbs = &{1'b0, host_ptr_addr[1:0]};

   assign w_pending = enable && (committed_ptr != r_last_sent);
   assign w_start   = rx_turn && w_pending && trn_tbuf_av;
   // A beat is consumed only when both sides are ready; src_rdy_n is low
   // exactly while a packet is in flight.
   assign w_accept  = !r_tx.src_rdy_n && !trn_tdst_rdy_n;

   // Header is built from the snapshot that will be current next cycle, so the
   // first beat can be registered in the same cycle the grant is taken.
   tlp_mwr1_hdr_gen #(
      .TLP_TAG (TLP_TAG),
      .TLP_TC  (TLP_TC)
   ) u_hdr_gen (
      .i_addr_hi      (w_snap_addr_next[61:30]),
      .i_completer_id (cfg_completer_id),
      .o_use4dw       (w_use4dw),
      .o_dw0          (w_dw0),
      .o_dw1          (w_dw1)
   );

   assign w_payload = byte_swap32(w_snap_ptr_next);

   // Next-state logic: take a grant in IDLE, step beats on accept, record the
   // reported pointer when the EOF beat is accepted.
   always_comb begin
      w_state_next     = r_state;
      w_last_sent_next = r_last_sent;
      w_snap_ptr_next  = r_snap_ptr;
      w_snap_addr_next = r_snap_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_next     = ST_BEAT0;
               w_snap_ptr_next  = committed_ptr;
               w_snap_addr_next = host_ptr_addr[63:2];
            end
         end
         ST_BEAT0: begin
            if (w_accept) begin
               w_state_next = ST_BEAT1;
            end
         end
         ST_BEAT1: begin
            if (w_accept) begin
               if (w_use4dw) begin
                  w_state_next = ST_BEAT2;
               end else begin
                  w_state_next     = ST_IDLE;
                  w_last_sent_next = r_snap_ptr;
               end
            end
         end
         ST_BEAT2: begin
            if (w_accept) begin
               w_state_next     = ST_IDLE;
               w_last_sent_next = r_snap_ptr;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Output decode for the upcoming state; a stalled beat recomputes the same
   // values from unchanged state and snapshot, so the bus holds stable.
   always_comb begin
      w_tx_next = TRN_TX_IDLE;
      case (w_state_next)
         ST_BEAT0: begin
            w_tx_next.driven    = 1'b1;
            w_tx_next.sof_n     = 1'b0;
            w_tx_next.src_rdy_n = 1'b0;
            w_tx_next.td        = {w_dw0, w_dw1};
         end
         ST_BEAT1: begin
            w_tx_next.driven    = 1'b1;
            w_tx_next.src_rdy_n = 1'b0;
            if (w_use4dw) begin
               w_tx_next.td = {w_snap_addr_next[61:30], w_snap_addr_next[29:0], 2'b00};
            end else begin
               w_tx_next.td     = {w_snap_addr_next[29:0], 2'b00, w_payload};
               w_tx_next.eof_n  = 1'b0;
               w_tx_next.trem_n = TRN_REM_BOTH;
            end
         end
         ST_BEAT2: begin
            w_tx_next.driven    = 1'b1;
            w_tx_next.src_rdy_n = 1'b0;
            w_tx_next.eof_n     = 1'b0;
            w_tx_next.trem_n    = TRN_REM_UPPER;
            w_tx_next.td        = {w_payload, 32'h0};
         end
         default: begin
            w_tx_next = TRN_TX_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge trn_clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Snapshot, last-reported pointer and registered TX outputs.
   always_ff @(posedge trn_clk) begin
      if (!reset_n) begin
         r_last_sent <= 32'h0;
         r_snap_ptr  <= 32'h0;
         r_snap_addr <= 62'h0;
         r_tx        <= TRN_TX_IDLE;
      end else begin
         r_last_sent <= w_last_sent_next;
         r_snap_ptr  <= w_snap_ptr_next;
         r_snap_addr <= w_snap_addr_next;
         r_tx        <= w_tx_next;
      end
   end

   assign rx_driven      = r_tx.driven;
   assign trn_td         = r_tx.td;
   assign trn_trem_n     = r_tx.trem_n;
   assign trn_tsof_n     = r_tx.sof_n;
   assign trn_teof_n     = r_tx.eof_n;
   assign trn_tsrc_rdy_n = r_tx.src_rdy_n;

endmodule

// File: tb/tb_rx_host_ptr_update.sv
// Directed bench for rx_host_ptr_update. Inputs change and outputs are
// sampled on the falling clock edge. Each observation is the packed vector
// {rx_driven, sof_n, eof_n, src_rdy_n, trem_n, td}.
module tb_rx_host_ptr_update;

   logic        trn_clk = 1'b0;
   logic        reset_n;
   logic        rx_turn;
   logic        rx_driven;
   logic        enable;
   logic [63:0] host_ptr_addr;
   logic [31:0] committed_ptr;
   logic [15:0] cfg_completer_id;
   logic [63:0] trn_td;
   logic [7:0]  trn_trem_n;
   logic        trn_tsof_n;
   logic        trn_teof_n;
   logic        trn_tsrc_rdy_n;
   logic        trn_tdst_rdy_n;
   logic        trn_tbuf_av;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [75:0] w_obs;
   assign w_obs = {rx_driven, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n, trn_td};

   // Expected vectors (completer ID 16'h0108 -> DW1 = 32'h0108_000F).
   localparam logic [75:0] IDLE_V  = {1'b0, 3'b111, 8'h00, 64'h0};
   localparam logic [75:0] B0_3DW  = {1'b1, 3'b010, 8'h00, 32'h4000_0001, 32'h0108_000F};
   localparam logic [75:0] B0_4DW  = {1'b1, 3'b010, 8'h00, 32'h6000_0001, 32'h0108_000F};

   always #5 trn_clk = ~trn_clk;

   rx_host_ptr_update dut (
      .trn_clk          (trn_clk),
      .reset_n          (reset_n),
      .rx_turn          (rx_turn),
      .rx_driven        (rx_driven),
      .enable           (enable),
      .host_ptr_addr    (host_ptr_addr),
      .committed_ptr    (committed_ptr),
      .cfg_completer_id (cfg_completer_id),
      .trn_td           (trn_td),
      .trn_trem_n       (trn_trem_n),
      .trn_tsof_n       (trn_tsof_n),
      .trn_teof_n       (trn_teof_n),
      .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
      .trn_tdst_rdy_n   (trn_tdst_rdy_n),
      .trn_tbuf_av      (trn_tbuf_av)
   );

   // One-cycle grant pulse; returns at the falling edge after it was sampled.
   task automatic grant();
      rx_turn = 1'b1;
      @(negedge trn_clk);
      rx_turn = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL reset_hold: got %h expected %h", w_obs, IDLE_V); end
      reset_n = 1'b1;
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL reset_release: got %h expected %h", w_obs, IDLE_V); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_3dw();
      logic [75:0] exp_v;
      host_ptr_addr = 64'h0000_0000_1000_0040;
      committed_ptr = 32'h0000_0123;
      grant();
      tests_run++;
      if (w_obs !== B0_3DW) begin tests_failed++; $display("FAIL 3dw_beat0: got %h expected %h", w_obs, B0_3DW); end
      @(negedge trn_clk);
      exp_v = {1'b1, 3'b100, 8'h00, 32'h1000_0040, 32'h2301_0000};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL 3dw_beat1: got %h expected %h", w_obs, exp_v); end
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL 3dw_release: got %h expected %h", w_obs, IDLE_V); end
      $display("[TB] test_3dw done");
   endtask

   task automatic test_4dw();
      logic [75:0] exp_v;
      host_ptr_addr = 64'h0000_0001_2000_0000;
      committed_ptr = 32'hAABB_CCDD;
      grant();
      tests_run++;
      if (w_obs !== B0_4DW) begin tests_failed++; $display("FAIL 4dw_beat0: got %h expected %h", w_obs, B0_4DW); end
      @(negedge trn_clk);
      exp_v = {1'b1, 3'b110, 8'h00, 32'h0000_0001, 32'h2000_0000};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL 4dw_beat1: got %h expected %h", w_obs, exp_v); end
      @(negedge trn_clk);
      exp_v = {1'b1, 3'b100, 8'h0F, 32'hDDCC_BBAA, 32'h0};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL 4dw_beat2: got %h expected %h", w_obs, exp_v); end
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL 4dw_release: got %h expected %h", w_obs, IDLE_V); end
      $display("[TB] test_4dw done");
   endtask

   task automatic test_noop();
      host_ptr_addr = 64'h0000_0000_1000_0040;
      // Pointer equal to the last report.
      grant();
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL noop_same_ptr: got %h expected %h", w_obs, IDLE_V); end
      // New pointer but reporting disabled.
      committed_ptr = 32'h0000_0077;
      enable = 1'b0;
      grant();
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL noop_disabled: got %h expected %h", w_obs, IDLE_V); end
      // Enabled but no posted buffer available.
      enable = 1'b1;
      trn_tbuf_av = 1'b0;
      grant();
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL noop_no_tbuf: got %h expected %h", w_obs, IDLE_V); end
      trn_tbuf_av = 1'b1;
      $display("[TB] test_noop done");
   endtask

   task automatic test_backpressure();
      logic [75:0] exp_v;
      // 0x77 is still pending from the no-op test.
      grant();
      tests_run++;
      if (w_obs !== B0_3DW) begin tests_failed++; $display("FAIL bp_beat0: got %h expected %h", w_obs, B0_3DW); end
      @(negedge trn_clk);
      trn_tdst_rdy_n = 1'b1;
      exp_v = {1'b1, 3'b100, 8'h00, 32'h1000_0040, 32'h7700_0000};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL bp_beat1: got %h expected %h", w_obs, exp_v); end
      for (int i = 0; i < 5; i++) begin
         // A grant arriving mid-packet must be ignored.
         rx_turn = (i == 2);
         @(negedge trn_clk);
         rx_turn = 1'b0;
         tests_run++;
         if (w_obs !== exp_v) begin tests_failed++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, w_obs, exp_v); end
      end
      trn_tdst_rdy_n = 1'b0;
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL bp_release: got %h expected %h", w_obs, IDLE_V); end
      $display("[TB] test_backpressure done");
   endtask

   task automatic test_ptr_change();
      logic [75:0] exp_v;
      committed_ptr = 32'h0000_0005;
      grant();
      tests_run++;
      if (w_obs !== B0_3DW) begin tests_failed++; $display("FAIL chg_beat0: got %h expected %h", w_obs, B0_3DW); end
      committed_ptr = 32'h0000_0006;
      host_ptr_addr = 64'h0000_0002_0000_0000;
      @(negedge trn_clk);
      exp_v = {1'b1, 3'b100, 8'h00, 32'h1000_0040, 32'h0500_0000};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL chg_beat1_old: got %h expected %h", w_obs, exp_v); end
      host_ptr_addr = 64'h0000_0000_1000_0040;
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL chg_release: got %h expected %h", w_obs, IDLE_V); end
      grant();
      tests_run++;
      if (w_obs !== B0_3DW) begin tests_failed++; $display("FAIL chg_new_beat0: got %h expected %h", w_obs, B0_3DW); end
      @(negedge trn_clk);
      exp_v = {1'b1, 3'b100, 8'h00, 32'h1000_0040, 32'h0600_0000};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL chg_new_beat1: got %h expected %h", w_obs, exp_v); end
      @(negedge trn_clk);
      grant();
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL chg_then_noop: got %h expected %h", w_obs, IDLE_V); end
      $display("[TB] test_ptr_change done");
   endtask

   task automatic test_reset_mid();
      logic [75:0] exp_v;
      committed_ptr = 32'h0000_0009;
      grant();
      tests_run++;
      if (w_obs !== B0_3DW) begin tests_failed++; $display("FAIL rst_beat0: got %h expected %h", w_obs, B0_3DW); end
      @(negedge trn_clk);
      exp_v = {1'b1, 3'b100, 8'h00, 32'h1000_0040, 32'h0900_0000};
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL rst_beat1: got %h expected %h", w_obs, exp_v); end
      reset_n = 1'b0;
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL rst_abort: got %h expected %h", w_obs, IDLE_V); end
      reset_n = 1'b1;
      @(negedge trn_clk);
      // last_sent is back to zero, so a zero pointer is not pending.
      committed_ptr = 32'h0;
      grant();
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL rst_zero_noop: got %h expected %h", w_obs, IDLE_V); end
      committed_ptr = 32'h0000_0009;
      grant();
      tests_run++;
      if (w_obs !== B0_3DW) begin tests_failed++; $display("FAIL rst_resend_beat0: got %h expected %h", w_obs, B0_3DW); end
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== exp_v) begin tests_failed++; $display("FAIL rst_resend_beat1: got %h expected %h", w_obs, exp_v); end
      @(negedge trn_clk);
      tests_run++;
      if (w_obs !== IDLE_V) begin tests_failed++; $display("FAIL rst_resend_release: got %h expected %h", w_obs, IDLE_V); end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      reset_n          = 1'b0;
      rx_turn          = 1'b0;
      enable           = 1'b1;
      host_ptr_addr    = 64'h0;
      committed_ptr    = 32'h0;
      cfg_completer_id = 16'h0108;
      trn_tdst_rdy_n   = 1'b0;
      trn_tbuf_av      = 1'b1;
      @(negedge trn_clk);
      test_reset();
      test_3dw();
      test_4dw();
      test_noop();
      test_backpressure();
      test_ptr_change();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
